// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, DEPTH-entry {pc,instr} FIFO, registered decode output.
// First command 4 edges after reset release; stop freezes the output and halts fetching once the FIFO is full.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] command,
    output logic [31:0] out_now_pc,
    output logic        bubble
);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   addr_q;
    logic          discard_q;
    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW:0]   count_q;
    logic [PW:0]   count_d;
    logic [31:0]   cmd_q;
    logic [31:0]   pc_q;
    logic          bubble_q;

    logic [31:0]   jump_tgt;
    logic [31:0]   next_addr;
    logic          push;
    logic          pop;

    assign jump_tgt  = jump_pc & 32'hFFFF_FFFC;
    assign next_addr = jump ? jump_tgt : fetch_pc_q;

    // A jump kills any same-cycle response, including one that is not marked for discard.
    assign push = (state_q == S_WAIT) && imem_rvalid && !discard_q && !jump;
    assign pop  = !jump && !stop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (jump) begin
            count_d = '0;
        end else begin
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (jump) begin
                        fetch_pc_q <= jump_tgt;
                    end
                    if (jump || (count_q < FULL)) begin
                        state_q <= S_REQ;
                        addr_q  <= next_addr;
                    end
                end
                S_REQ: begin
                    // A request made stale by an earlier jump must not advance fetch_pc past the target.
                    if (jump) begin
                        fetch_pc_q <= jump_tgt;
                        discard_q  <= 1'b1;
                    end else if (imem_gnt && !discard_q) begin
                        fetch_pc_q <= addr_q + 32'd4;
                    end
                    if (imem_gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (jump) begin
                        fetch_pc_q <= jump_tgt;
                    end
                    if (imem_rvalid) begin
                        discard_q <= 1'b0;
                        if (count_d < FULL) begin
                            state_q <= S_REQ;
                            addr_q  <= next_addr;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (jump) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: addr_q, instr: imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= NOP;
            pc_q     <= '0;
            bubble_q <= 1'b1;
        end else begin
            count_q <= count_d;
            if (jump) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cmd_q    <= NOP;
                pc_q     <= jump_tgt;
                bubble_q <= 1'b1;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    cmd_q    <= fifo_q[rd_ptr_q].instr;
                    pc_q     <= fifo_q[rd_ptr_q].pc;
                    bubble_q <= 1'b0;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end else if (!stop) begin
                    cmd_q    <= NOP;
                    bubble_q <= 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL);

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = addr_q;
    assign command    = cmd_q;
    assign out_now_pc = pc_q;
    assign bubble     = bubble_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted memory with variable latency, scoreboard of returned words, directed corner cases.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stop = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] command;
    logic [31:0] out_now_pc;
    logic        bubble;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .jump(jump), .jump_pc(jump_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .command(command), .out_now_pc(out_now_pc), .bubble(bubble)
    );

    int checks = 0;
    int passes = 0;
    bit gnt_en = 1'b1;
    int lat = 1;

    assign imem_gnt = imem_req & gnt_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    bit          pend = 1'b0, pend_stale = 1'b0, req_stale = 1'b0;
    bit          rv, rstale;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0, raddr = 32'h0;
    logic [31:0] next_addr = RST_PC;
    bit          stop_seen = 1'b0;

    // Memory responder plus output scoreboard; inputs for the coming edge are stable at the negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0; pend_stale = 0; req_stale = 0; stop_seen = 0;
            exp_q.delete();
            next_addr = RST_PC;
            imem_rvalid = 1'b0;
        end else begin
            if (!stop_seen) begin
                if (!bubble) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_unexpected: got pc %h cmd %h, none expected", out_now_pc, command);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", out_now_pc, e.pc);
                        check("sb_cmd", command, e.ins);
                    end
                end else begin
                    check("sb_nop", command, NOP);
                end
            end
            rv = 0; rstale = 0;
            if (pend) begin
                if (cnt <= 1) begin
                    rv = 1; raddr = pend_addr; rstale = pend_stale; pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (rv && !rstale && !jump) begin
                e.pc = raddr; e.ins = raddr ^ XMASK;
                exp_q.push_back(e);
            end
            if (jump) begin
                exp_q.delete();
                next_addr = jump_pc & 32'hFFFF_FFFC;
                if (pend) pend_stale = 1;
                else if (imem_req) req_stale = 1;
            end
            if (imem_req && imem_gnt) begin
                if (!req_stale) begin
                    check("req_addr", imem_addr, next_addr);
                    next_addr = next_addr + 32'd4;
                end
                pend = 1; pend_addr = imem_addr; cnt = lat;
                pend_stale = req_stale; req_stale = 0;
            end
            imem_rvalid = rv;
            imem_rdata  = rv ? (raddr ^ XMASK) : 32'hDEAD_BEEF;
            stop_seen   = stop;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!bubble) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL %s: no valid command within 40 cycles", name);
        end
    endtask

    typedef struct {
        logic [31:0] jpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 1};
        vecs[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 2};
        vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1};
        vecs[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004, 3};
        vecs[4] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd", command, NOP);
        check("rst_bubble", bubble, 1);
        check("rst_pc", out_now_pc, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);

        rst_n = 1'b1;
        step();
        check("e1_req", imem_req, 1);
        check("e1_addr", imem_addr, RST_PC);
        step(); check("e2_bubble", bubble, 1);
        step(); check("e3_bubble", bubble, 1);
        step();
        check("e4_bubble", bubble, 0);
        check("e4_pc", out_now_pc, RST_PC);
        check("e4_cmd", command, RST_PC ^ XMASK);
        step(); check("e5_bubble", bubble, 1);
        step();
        check("e6_bubble", bubble, 0);
        check("e6_pc", out_now_pc, RST_PC + 32'd4);
        step(); check("e7_bubble", bubble, 1);
        step();
        check("e8_pc", out_now_pc, RST_PC + 32'd8);

        stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stop_pc", out_now_pc, 32'h108);
            check("stop_cmd", command, 32'h108 ^ XMASK);
            check("stop_bubble", bubble, 0);
            if (i >= 2) check("stop_req", imem_req, 0);
        end
        stop = 1'b0;
        step();
        check("rel0_bubble", bubble, 0);
        check("rel0_pc", out_now_pc, 32'h10C);
        step();
        check("rel1_bubble", bubble, 0);
        check("rel1_pc", out_now_pc, 32'h110);
        check("rel1_req", imem_req, 1);
        check("rel1_addr", imem_addr, 32'h114);

        lat = 3;
        step();
        jump = 1'b1; jump_pc = 32'h200;
        step();
        check("jw_bubble", bubble, 1);
        check("jw_pc", out_now_pc, 32'h200);
        check("jw_cmd", command, NOP);
        check("jw_req", imem_req, 0);
        jump = 1'b0; lat = 1;
        step();
        check("jw_req_wait", imem_req, 0);
        step();
        check("jw_req_tgt", imem_req, 1);
        check("jw_addr_tgt", imem_addr, 32'h200);
        wait_valid("jw_first");
        check("jw_first_pc", out_now_pc, 32'h200);
        check("jw_first_cmd", command, 32'h200 ^ XMASK);

        gnt_en = 1'b0;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        check("jr_req", imem_req, 1);
        check("jr_old_addr", imem_addr, 32'h208);
        jump = 1'b1; jump_pc = 32'h200;
        step();
        check("jr_bubble", bubble, 1);
        check("jr_pc", out_now_pc, 32'h200);
        jump = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("jr_hold_req", imem_req, 1);
            check("jr_hold_addr", imem_addr, 32'h208);
            if (i < 3) step();
        end
        gnt_en = 1'b1;
        step();
        step();
        check("jr_new_req", imem_req, 1);
        check("jr_new_addr", imem_addr, 32'h200);
        wait_valid("jr_first");
        check("jr_first_pc", out_now_pc, 32'h200);

        stop = 1'b1;
        repeat (6) step();
        check("js_full_idle", imem_req, 0);
        jump = 1'b1; jump_pc = 32'h400;
        step();
        check("js_bubble", bubble, 1);
        check("js_pc", out_now_pc, 32'h400);
        check("js_cmd", command, NOP);
        jump = 1'b0; stop = 1'b0;
        wait_valid("js_first");
        check("js_first_pc", out_now_pc, 32'h400);
        check("js_first_cmd", command, 32'h400 ^ XMASK);

        for (int v = 0; v < 5; v++) begin
            lat = vecs[v].lat;
            jump = 1'b1; jump_pc = vecs[v].jpc;
            step();
            jump = 1'b0;
            wait_valid("vec_first");
            check("vec_pc0", out_now_pc, vecs[v].pc0);
            check("vec_cmd0", command, vecs[v].pc0 ^ XMASK);
            wait_valid("vec_second");
            check("vec_pc1", out_now_pc, vecs[v].pc1);
            check("vec_cmd1", command, vecs[v].pc1 ^ XMASK);
        end

        lat = 1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd", command, NOP);
        check("mid_rst_bubble", bubble, 1);
        check("mid_rst_pc", out_now_pc, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
